// File: rtl/d_ff_pkg.sv
// Shared helpers for the d_ff register pipeline: occupancy counter width and
// the default per-bit reset level used to build RESET_VALUE.
package d_ff_pkg;

  localparam logic D_FF_RESET_BIT = 1'b0;

  // Bits needed to hold an occupancy from 0 up to and including depth.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/d_ff_stage.sv
// One pipeline slot: a valid bit plus data register. It loads whenever it is
// empty or the downstream slot can take its current contents.
module d_ff_stage
  import d_ff_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{D_FF_RESET_BIT}}
) (
  input  logic             clk,
  input  logic             sync_reset,
  input  logic             i_flush,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_rdy_in,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_rdy_out
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  assign o_rdy_out = ~r_valid | i_rdy_in;
  assign o_valid   = r_valid;
  assign o_data    = r_data;

  // Data only moves with a valid token, so bubbles never toggle the register.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      r_valid <= 1'b0;
      r_data  <= RESET_VALUE;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (o_rdy_out) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data <= i_data;
      end
    end
  end

endmodule

// File: rtl/d_ff_pipeline.sv
// DEPTH-stage valid/ready register pipeline with bubble collapsing, flush and
// an occupancy count; the standard delay/retiming element for datapaths.
module d_ff_pipeline
  import d_ff_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               DEPTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{D_FF_RESET_BIT}}
) (
  input  logic                          clk,
  input  logic                          sync_reset,
  input  logic                          i_flush,
  input  logic                          i_valid,
  input  logic [WIDTH-1:0]              i_value,
  output logic                          o_ready,
  output logic                          o_valid,
  output logic [WIDTH-1:0]              o_value,
  input  logic                          i_ready,
  output logic [count_width(DEPTH)-1:0] o_count,
  output logic                          o_full,
  output logic                          o_empty
);

  localparam int            CW      = count_width(DEPTH);
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  // Handshake rule: a transfer happens on a rising edge where valid and ready
  // are both high; ready may depend combinationally on downstream ready.
  logic [DEPTH-1:0] w_valid;
  logic [DEPTH-1:0] w_rdy_in;
  logic [DEPTH-1:0] w_rdy_out;
  logic [WIDTH-1:0] w_data [DEPTH];
  logic             w_in_hs;
  logic             w_out_hs;
  logic [CW-1:0]    r_count;

  // Ready into stage k is high unless stages k+1..DEPTH-1 are all full and
  // downstream stalls; built from registered valids so no comb loop forms.
  always_comb begin : ready_chain
    logic v_acc;
    v_acc = i_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      w_rdy_in[k] = v_acc;
      v_acc       = v_acc | ~w_valid[k];
    end
  end

  // Stage 0 ready dominates every later stage ready, so the OR equals it.
  assign o_ready  = (|w_rdy_out) & ~i_flush;
  assign w_in_hs  = i_valid & o_ready;
  assign o_valid  = w_valid[DEPTH-1];
  assign o_value  = w_data[DEPTH-1];
  assign w_out_hs = o_valid & i_ready;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic             w_stage_valid;
    logic [WIDTH-1:0] w_stage_data;

    if (k == 0) begin : g_head
      assign w_stage_valid = w_in_hs;
      assign w_stage_data  = i_value;
    end else begin : g_body
      assign w_stage_valid = w_valid[k-1];
      assign w_stage_data  = w_data[k-1];
    end

    d_ff_stage #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUE)
    ) u_stage (
      .clk        (clk),
      .sync_reset (sync_reset),
      .i_flush    (i_flush),
      .i_valid    (w_stage_valid),
      .i_data     (w_stage_data),
      .i_rdy_in   (w_rdy_in[k]),
      .o_valid    (w_valid[k]),
      .o_data     (w_data[k]),
      .o_rdy_out  (w_rdy_out[k])
    );
  end

  always_ff @(posedge clk) begin
    if (sync_reset || i_flush) begin
      r_count <= '0;
    end else if (w_in_hs && !w_out_hs) begin
      r_count <= r_count + CW'(1);
    end else if (!w_in_hs && w_out_hs) begin
      r_count <= r_count - CW'(1);
    end
  end

  assign o_count = r_count;
  assign o_full  = (r_count == C_DEPTH);
  assign o_empty = (r_count == '0);

endmodule

// File: tb/tb_d_ff_pipeline.sv
// Directed bench for d_ff_pipeline with WIDTH=8, DEPTH=3, RESET_VALUE=8'hA5.
module tb_d_ff_pipeline;

  logic       clk;
  logic       sync_reset;
  logic       i_flush;
  logic       i_valid;
  logic [7:0] i_value;
  logic       o_ready;
  logic       o_valid;
  logic [7:0] o_value;
  logic       i_ready;
  logic [1:0] o_count;
  logic       o_full;
  logic       o_empty;

  int checks;
  int errors;

  d_ff_pipeline #(
    .WIDTH       (8),
    .DEPTH       (3),
    .RESET_VALUE (8'hA5)
  ) dut (
    .clk        (clk),
    .sync_reset (sync_reset),
    .i_flush    (i_flush),
    .i_valid    (i_valid),
    .i_value    (i_value),
    .o_ready    (o_ready),
    .o_valid    (o_valid),
    .o_value    (o_value),
    .i_ready    (i_ready),
    .o_count    (o_count),
    .o_full     (o_full),
    .o_empty    (o_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    sync_reset = 1'b1; i_flush = 1'b0; i_valid = 1'b1; i_value = 8'h3C; i_ready = 1'b0;
    tick();
    sync_reset = 1'b0; i_valid = 1'b0;
    #1;
    checks++; if (o_value !== 8'hA5) begin errors++; $display("FAIL reset_value: got %h want a5", o_value); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    checks++; if (o_count !== 2'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", o_count); end
    checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", o_empty); end
    checks++; if (o_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", o_full); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", o_ready); end
  endtask

  // Items 1..8 on edges 0..7; item accepted at edge c shows after edge c+2.
  task automatic test_streaming();
    logic [1:0] exp_cnt;
    logic       exp_vld;
    i_ready = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      i_valid = (c < 8);
      i_value = 8'(c + 1);
      #1;
      checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL stream_ready c=%0d: got %b want 1", c, o_ready); end
      tick();
      exp_vld = (c >= 2) && (c <= 9);
      exp_cnt = 2'((c + 1 < 8 ? c + 1 : 8) - (c > 2 ? c - 2 : 0));
      checks++; if (o_valid !== exp_vld) begin errors++; $display("FAIL stream_valid c=%0d: got %b want %b", c, o_valid, exp_vld); end
      if (exp_vld) begin
        checks++; if (o_value !== 8'(c - 1)) begin errors++; $display("FAIL stream_value c=%0d: got %h want %h", c, o_value, 8'(c - 1)); end
      end
      checks++; if (o_count !== exp_cnt) begin errors++; $display("FAIL stream_count c=%0d: got %0d want %0d", c, o_count, exp_cnt); end
    end
    i_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_value = 8'h10; #1;
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL bp_ready0: got %b want 1", o_ready); end
    tick();
    i_value = 8'h11; tick();
    i_value = 8'h12; tick();
    checks++; if (o_full !== 1'b1) begin errors++; $display("FAIL bp_full: got %b want 1", o_full); end
    checks++; if (o_count !== 2'd3) begin errors++; $display("FAIL bp_count3: got %0d want 3", o_count); end
    checks++; if (o_value !== 8'h10) begin errors++; $display("FAIL bp_head: got %h want 10", o_value); end
    i_value = 8'h13; #1;
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL bp_stall_ready: got %b want 0", o_ready); end
    tick();
    checks++; if (o_value !== 8'h10 || o_count !== 2'd3) begin errors++; $display("FAIL bp_hold: got %h/%0d want 10/3", o_value, o_count); end
    i_ready = 1'b1; #1;
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", o_ready); end
    tick();
    i_valid = 1'b0;
    checks++; if (o_value !== 8'h11 || o_count !== 2'd3) begin errors++; $display("FAIL bp_drain1: got %h/%0d want 11/3", o_value, o_count); end
    tick();
    checks++; if (o_value !== 8'h12 || o_count !== 2'd2) begin errors++; $display("FAIL bp_drain2: got %h/%0d want 12/2", o_value, o_count); end
    tick();
    checks++; if (o_value !== 8'h13 || o_valid !== 1'b1 || o_count !== 2'd1) begin errors++; $display("FAIL bp_drain3: got %h/%b/%0d want 13/1/1", o_value, o_valid, o_count); end
    tick();
    checks++; if (o_valid !== 1'b0 || o_empty !== 1'b1) begin errors++; $display("FAIL bp_empty: got valid %b empty %b want 0/1", o_valid, o_empty); end
  endtask

  task automatic test_bubble();
    i_ready = 1'b0;
    i_valid = 1'b1; i_value = 8'h20; tick();
    i_valid = 1'b0; tick();
    i_valid = 1'b1; i_value = 8'h21; tick();
    i_valid = 1'b0; tick();
    tick();
    checks++; if (o_count !== 2'd2) begin errors++; $display("FAIL bubble_count: got %0d want 2", o_count); end
    checks++; if (o_valid !== 1'b1 || o_value !== 8'h20) begin errors++; $display("FAIL bubble_head: got %b/%h want 1/20", o_valid, o_value); end
    checks++; if (o_ready !== 1'b1 || o_full !== 1'b0) begin errors++; $display("FAIL bubble_room: got ready %b full %b want 1/0", o_ready, o_full); end
    i_ready = 1'b1;
    tick();
    checks++; if (o_valid !== 1'b1 || o_value !== 8'h21) begin errors++; $display("FAIL bubble_nogap: got %b/%h want 1/21", o_valid, o_value); end
    tick();
    checks++; if (o_valid !== 1'b0 || o_count !== 2'd0) begin errors++; $display("FAIL bubble_drained: got %b/%0d want 0/0", o_valid, o_count); end
  endtask

  task automatic test_flush();
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_value = 8'h30; tick();
    i_value = 8'h31; tick();
    i_value = 8'h32; tick();
    checks++; if (o_full !== 1'b1) begin errors++; $display("FAIL flush_prefill: got full %b want 1", o_full); end
    i_ready = 1'b1; i_flush = 1'b1; i_value = 8'h33; #1;
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b want 0", o_ready); end
    tick();
    i_flush = 1'b0; i_valid = 1'b0; #1;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", o_valid); end
    checks++; if (o_count !== 2'd0 || o_empty !== 1'b1) begin errors++; $display("FAIL flush_count: got %0d empty %b want 0/1", o_count, o_empty); end
    checks++; if (o_value !== 8'h30) begin errors++; $display("FAIL flush_data_kept: got %h want 30", o_value); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL flush_ready_after: got %b want 1", o_ready); end
    tick();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL flush_no_accept: got %b want 0", o_valid); end
  endtask

  task automatic test_reset_vs_flush();
    i_ready = 1'b1;
    i_valid = 1'b1;
    i_value = 8'h40; tick();
    i_value = 8'h41; tick();
    i_value = 8'h42; tick();
    checks++; if (o_valid !== 1'b1 || o_value !== 8'h40) begin errors++; $display("FAIL rf_midstream: got %b/%h want 1/40", o_valid, o_value); end
    sync_reset = 1'b1; i_flush = 1'b1; i_value = 8'h43;
    tick();
    sync_reset = 1'b0; i_flush = 1'b0; i_valid = 1'b0; #1;
    checks++; if (o_value !== 8'hA5 || o_valid !== 1'b0) begin errors++; $display("FAIL rf_reset_state: got %h/%b want a5/0", o_value, o_valid); end
    checks++; if (o_count !== 2'd0 || o_empty !== 1'b1) begin errors++; $display("FAIL rf_count: got %0d empty %b want 0/1", o_count, o_empty); end
    tick(); tick();
    checks++; if (o_valid !== 1'b0 || o_count !== 2'd0) begin errors++; $display("FAIL rf_no_accept: got %b/%0d want 0/0", o_valid, o_count); end
    i_valid = 1'b1; i_value = 8'h50; tick();
    i_valid = 1'b0; tick();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rf_latency_early: got %b want 0", o_valid); end
    tick();
    checks++; if (o_valid !== 1'b1 || o_value !== 8'h50) begin errors++; $display("FAIL rf_latency: got %b/%h want 1/50", o_valid, o_value); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    sync_reset = 1'b0;
    i_flush    = 1'b0;
    i_valid    = 1'b0;
    i_value    = 8'h00;
    i_ready    = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_bubble();
    test_flush();
    test_reset_vs_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
